tx_scramble_ctrl: RTL

TX_SCRAMBLE_CTRL -- requirements
Module: tx_scramble_ctrl

---
 rtl/tx_scramble_ctrl_if.sv | 26 ++
 rtl/tx_scramble_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tx_scramble_ctrl_if.sv
// TX symbol bus between the PIPE data source and the scrambler controller.
// The blkAlignErr flag exists only when TX_SCR_BLKALIGN_CHK_EN is defined.
interface tx_scramble_ctrl_if #(parameter int DATA_BYTES = 4);
  logic                    dataValid;
  logic                    blockStart;
  logic [1:0]              syncHeader;
  logic [8*DATA_BYTES-1:0] masterData;
  logic                    patternReset;
  logic [1:0]              LFSRSel;
  logic [DATA_BYTES-1:0]   advance;
  logic [DATA_BYTES-1:0]   scramblingEnable;
  logic [8*DATA_BYTES-1:0] dataOut;
`ifdef TX_SCR_BLKALIGN_CHK_EN
  logic                    blkAlignErr;

  modport master (output dataValid, blockStart, syncHeader, masterData,
                  input  patternReset, LFSRSel, advance, scramblingEnable, dataOut, blkAlignErr);
  modport slave  (input  dataValid, blockStart, syncHeader, masterData,
                  output patternReset, LFSRSel, advance, scramblingEnable, dataOut, blkAlignErr);
`else
  modport master (output dataValid, blockStart, syncHeader, masterData,
                  input  patternReset, LFSRSel, advance, scramblingEnable, dataOut);
  modport slave  (input  dataValid, blockStart, syncHeader, masterData,
                  output patternReset, LFSRSel, advance, scramblingEnable, dataOut);
`endif
endinterface

// File: rtl/tx_scramble_ctrl.sv
// TX scrambler control: per-byte LFSR advance/scramble qualifiers for 8b/10b and 128b/130b.
// Define TX_SCR_BLKALIGN_CHK_EN to add the sticky blkAlignErr block-alignment flag.
//   state | meaning
//   IDLE  | no block decoded; nothing advanced or scrambled
//   DATA  | data block; advance and scramble all active bytes
//   TS    | training set; advance all, scramble all but symbol 0
//   SKP   | skip ordered set; frozen LFSR, unscrambled
//   EIEOS | electrical idle exit; advance, unscrambled, reseed after symbol 15
//   OS    | other ordered set; frozen LFSR, unscrambled
module tx_scramble_ctrl #(
  parameter int DATA_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  turnOff,
  input  logic [2:0]            GEN,
  input  logic [5:0]            PIPEWIDTH,
  tx_scramble_ctrl_if.slave     bus
);

  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;

  typedef enum logic [2:0] {IDLE, DATA, TS, SKP, EIEOS, OS} state_t;

  state_t                  state_q, state_nx, eff_state;
  logic [3:0]              sym_q, sym_nx, base, width_bytes, n_act;
  logic [4:0]              sym_sum;
  logic [1:0]              width_sel, lfsr_sel_q;
  logic [2:0]              gen_q;
  logic                    gen_seen_q, gen_chg, gen3;
  logic                    pend_q, pend_nx, pr_q, pr_nx;
  logic [DATA_BYTES-1:0]   act_mask, adv_q, adv_nx, scr_q, scr_nx;
  logic [8*DATA_BYTES-1:0] dout_q, dout_nx;
`ifdef TX_SCR_BLKALIGN_CHK_EN
  logic                    err_q, err_nx;
`endif

  function automatic state_t decode_block(input logic [1:0] sh, input logic [7:0] b0);
    state_t s;
    s = IDLE;
    if (sh == 2'b01) begin
      s = DATA;
    end else if (sh == 2'b10) begin
      case (b0)
        8'h00:        s = EIEOS;
        8'hAA:        s = SKP;
        8'h1E, 8'h2D: s = TS;
        default:      s = OS;
      endcase
    end
    return s;
  endfunction

  // PIPEWIDTH of 64 does not fit 6 bits; any unlisted code is treated as the 64-bit width.
  always_comb begin
    case (PIPEWIDTH)
      6'd8:    begin width_bytes = 4'd1; width_sel = 2'd0; end
      6'd16:   begin width_bytes = 4'd2; width_sel = 2'd1; end
      6'd32:   begin width_bytes = 4'd4; width_sel = 2'd2; end
      default: begin width_bytes = 4'd8; width_sel = 2'd3; end
    endcase
    n_act = (width_bytes < 4'(DATA_BYTES)) ? width_bytes : 4'(DATA_BYTES);
    for (int i = 0; i < DATA_BYTES; i++) act_mask[i] = (4'(i) < n_act);
  end

  assign gen3    = (GEN >= 3'd3);
  assign gen_chg = gen_seen_q && (GEN != gen_q);

  always_comb begin
    state_nx  = state_q;
    sym_nx    = sym_q;
    pend_nx   = 1'b0;
    pr_nx     = pend_q;
    adv_nx    = '0;
    scr_nx    = scr_q;
    dout_nx   = dout_q;
    eff_state = (gen3 && bus.blockStart) ? decode_block(bus.syncHeader, bus.masterData[7:0]) : state_q;
    base      = bus.blockStart ? 4'd0 : sym_q;
    sym_sum   = {1'b0, base} + {1'b0, n_act};
`ifdef TX_SCR_BLKALIGN_CHK_EN
    err_nx    = err_q;
`endif
    if (bus.dataValid) begin
      dout_nx = bus.masterData;
      scr_nx  = '0;
      if (!gen3) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (act_mask[i]) begin
            if (bus.masterData[8*i +: 8] == COM) pr_nx = 1'b1;
            adv_nx[i] = (bus.masterData[8*i +: 8] != SKP_SYM);
            scr_nx[i] = (bus.masterData[8*i +: 8] != COM) && (bus.masterData[8*i +: 8] != SKP_SYM);
          end
        end
      end else begin
        state_nx = eff_state;
        sym_nx   = sym_sum[3:0];
`ifdef TX_SCR_BLKALIGN_CHK_EN
        if (bus.blockStart && (sym_q != 4'd0)) err_nx = 1'b1;
`endif
        for (int i = 0; i < DATA_BYTES; i++) begin
          case (eff_state)
            DATA:    begin adv_nx[i] = act_mask[i]; scr_nx[i] = act_mask[i]; end
            TS:      begin
                       adv_nx[i] = act_mask[i];
                       scr_nx[i] = act_mask[i] && ((base + 4'(i)) != 4'd0);
                     end
            EIEOS:   adv_nx[i] = act_mask[i];
            default: ;
          endcase
        end
        // Symbol 15 rides on this beat when the running count crosses 16.
        pend_nx = (eff_state == EIEOS) && sym_sum[4];
      end
    end
    if (turnOff) begin
      pr_nx    = 1'b1;
      adv_nx   = act_mask;
      scr_nx   = '0;
      state_nx = IDLE;
      pend_nx  = 1'b0;
    end
    if (gen_chg) begin
      state_nx = IDLE;
      sym_nx   = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sym_q      <= 4'd0;
      gen_q      <= 3'd0;
      gen_seen_q <= 1'b0;
      pend_q     <= 1'b0;
      pr_q       <= 1'b1;
      adv_q      <= '0;
      scr_q      <= '0;
      dout_q     <= '0;
      lfsr_sel_q <= 2'd0;
`ifdef TX_SCR_BLKALIGN_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_nx;
      sym_q      <= sym_nx;
      gen_q      <= GEN;
      gen_seen_q <= 1'b1;
      pend_q     <= pend_nx;
      pr_q       <= pr_nx;
      adv_q      <= adv_nx;
      scr_q      <= scr_nx;
      dout_q     <= dout_nx;
      lfsr_sel_q <= width_sel;
`ifdef TX_SCR_BLKALIGN_CHK_EN
      err_q      <= err_nx;
`endif
    end
  end

  // While in reset the width select tracks PIPEWIDTH directly so the LFSR is sized before release.
  assign bus.LFSRSel          = reset ? width_sel : lfsr_sel_q;
  assign bus.patternReset     = pr_q;
  assign bus.advance          = adv_q;
  assign bus.scramblingEnable = scr_q;
  assign bus.dataOut          = dout_q;
`ifdef TX_SCR_BLKALIGN_CHK_EN
  assign bus.blkAlignErr      = err_q;
`endif

endmodule
